// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and constants for the 4x4 keypad scanner
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN        = 2'd0,
    DEB_PRESS   = 2'd1,
    HELD        = 2'd2,
    DEB_RELEASE = 2'd3
  } scan_state_t;

  function automatic int key_width(input int n_keys);
    return (n_keys > 1) ? $clog2(n_keys) : 1;
  endfunction

  localparam int KEY_W = key_width(16);

  // Board-labelled keys that are not plain digits
  localparam logic [KEY_W-1:0] KEY_STAR = 4'd12;
  localparam logic [KEY_W-1:0] KEY_HASH = 4'd14;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer, resets to all ones (idle keypad level)
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - column-scanning 4x4 keypad reader with press/release debounce
// and a valid/ready key-code output.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int N_ROWS         = 4,
  parameter int N_COLS         = 4,
  parameter int DEBOUNCE_SCANS = 4,
  localparam int CODE_W        = key_width(N_ROWS * N_COLS),
  localparam int ROW_W         = (N_ROWS > 1) ? $clog2(N_ROWS) : 1,
  localparam int COL_W         = (N_COLS > 1) ? $clog2(N_COLS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scan_tick,
  input  logic [N_ROWS-1:0] row_i,
  output logic [N_COLS-1:0] col_o,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  input  logic              key_ready,
  output logic              overrun
);

  scan_state_t state_q, state_d;

  logic [N_ROWS-1:0] row_s;
  logic [COL_W-1:0]  col_idx_q;
  logic [ROW_W-1:0]  cand_row_q;
  logic [ROW_W-1:0]  win_row;
  logic [ROW_W-1:0]  load_row;
  logic [3:0]        cnt_q;
  logic [3:0]        cnt_plus;
  logic              cand_low;
  logic              advance, latch, cnt_set, cnt_inc, load;

  sync_2ff #(.WIDTH(N_ROWS)) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d   (row_i),
    .q   (row_s)
  );

  // Lowest-numbered low row wins when several keys share the driven column
  always_comb begin
    win_row = '0;
    for (int r = N_ROWS - 1; r >= 0; r--) begin
      if (!row_s[r]) win_row = ROW_W'(r);
    end
  end

  assign cand_low = !row_s[cand_row_q];
  assign cnt_plus = cnt_q + 4'd1;
  assign load_row = latch ? win_row : cand_row_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= SCAN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    advance = 1'b0;
    latch   = 1'b0;
    cnt_set = 1'b0;
    cnt_inc = 1'b0;
    load    = 1'b0;
    if (scan_tick) begin
      unique case (state_q)
        SCAN: begin
          if (&row_s) begin
            advance = 1'b1;
          end else begin
            latch   = 1'b1;
            cnt_set = 1'b1;
            if (DEBOUNCE_SCANS == 1) begin
              load    = 1'b1;
              state_d = HELD;
            end else begin
              state_d = DEB_PRESS;
            end
          end
        end
        DEB_PRESS: begin
          if (cand_low) begin
            cnt_inc = 1'b1;
            if (cnt_plus == 4'(DEBOUNCE_SCANS)) begin
              load    = 1'b1;
              state_d = HELD;
            end
          end else begin
            advance = 1'b1;
            state_d = SCAN;
          end
        end
        HELD: begin
          if (!cand_low) begin
            cnt_set = 1'b1;
            if (DEBOUNCE_SCANS == 1) begin
              advance = 1'b1;
              state_d = SCAN;
            end else begin
              state_d = DEB_RELEASE;
            end
          end
        end
        DEB_RELEASE: begin
          if (!cand_low) begin
            cnt_inc = 1'b1;
            if (cnt_plus == 4'(DEBOUNCE_SCANS)) begin
              advance = 1'b1;
              state_d = SCAN;
            end
          end else begin
            state_d = HELD;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  always_comb begin
    col_o = ~(N_COLS'(1) << col_idx_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_idx_q  <= '0;
      cand_row_q <= '0;
      cnt_q      <= '0;
      key_code   <= '0;
      key_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (advance) begin
        col_idx_q <= (col_idx_q == COL_W'(N_COLS - 1)) ? '0 : col_idx_q + 1'b1;
      end
      if (latch) cand_row_q <= win_row;
      if (cnt_set)      cnt_q <= 4'd1;
      else if (cnt_inc) cnt_q <= cnt_plus;
      // A fresh load beats a same-edge acceptance; only an unaccepted code counts as lost
      if (load) begin
        key_code  <= CODE_W'(int'(load_row) * N_COLS + int'(col_idx_q));
        key_valid <= 1'b1;
        if (key_valid && !key_ready) overrun <= 1'b1;
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed bench with a key-code scoreboard for keypad_scanner
module tb_keypad_scanner;
  import keypad_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             scan_tick = 1'b0;
  logic [3:0]       row_i;
  logic [3:0]       col_o;
  logic [KEY_W-1:0] key_code;
  logic             key_valid;
  logic             key_ready;
  logic             overrun;

  logic [15:0]      pressed = '0;
  logic [KEY_W-1:0] exp_q[$];
  int               total = 0;
  int               bad = 0;
  int               n_accept = 0;
  int               div = 0;
  bit               found;

  keypad_scanner #(.N_ROWS(4), .N_COLS(4), .DEBOUNCE_SCANS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .scan_tick (scan_tick),
    .row_i     (row_i),
    .col_o     (col_o),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    div = (div == 7) ? 0 : div + 1;
    scan_tick = (div == 0);
  end

  // Keypad matrix: a pressed key pulls its row low while its column is driven
  always_comb begin
    row_i = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_o[c]) row_i[r] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (scan_tick !== 1'b1) @(posedge clk);
    end
  endtask

  task automatic wait_valid(input string tag);
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(posedge clk);
      #1;
      if (key_valid === 1'b1) found = 1'b1;
    end
    chk(tag, found, 1);
  endtask

  task automatic wait_col(input string tag, input logic [3:0] col);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      wait_ticks(1);
      #1;
      if (col_o === col) found = 1'b1;
    end
    chk(tag, found, 1);
  endtask

  // Scoreboard: each accepted handshake must deliver the next queued code
  always @(negedge clk) begin
    if (!rst && key_valid === 1'b1 && key_ready === 1'b1) begin
      n_accept++;
      chk("accept_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("accept_code", key_code, exp_q.pop_front());
    end
  end

  initial begin
    rst = 1'b1;
    key_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_col", col_o, 4'b1110);
    chk("rst_valid", key_valid, 0);
    chk("rst_code", key_code, 0);
    chk("rst_overrun", overrun, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 8; k++) begin
      wait_ticks(1);
      #1;
      chk("idle_col", col_o, 4'b1111 ^ (4'b0001 << ((k + 1) % 4)));
      chk("idle_valid", key_valid, 0);
    end

    // Key 9: row 2 on column 1, four sampled ticks to accept
    pressed[9] = 1'b1;
    exp_q.push_back(4'd9);
    wait_col("k9_col_reached", 4'b1101);
    wait_ticks(3);
    #1;
    chk("k9_not_yet", key_valid, 0);
    chk("k9_col_frozen", col_o, 4'b1101);
    wait_ticks(1);
    #1;
    chk("k9_valid", key_valid, 1);
    chk("k9_code", key_code, 9);
    @(posedge clk);
    #1;
    chk("k9_valid_drop", key_valid, 0);
    pressed[9] = 1'b0;
    wait_ticks(3);
    #1;
    chk("k9_release_hold", col_o, 4'b1101);
    wait_ticks(1);
    #1;
    chk("k9_release_done", col_o, 4'b1011);

    // Bounce on row 0, column 2
    pressed[2] = 1'b1;
    wait_ticks(1);
    #1;
    chk("bounce_freeze", col_o, 4'b1011);
    pressed[2] = 1'b0;
    wait_ticks(1);
    #1;
    chk("bounce_advance", col_o, 4'b0111);
    chk("bounce_valid", key_valid, 0);
    pressed[2] = 1'b1;
    wait_ticks(1);
    pressed[2] = 1'b0;
    wait_ticks(4);
    #1;
    chk("bounce_col", col_o, 4'b1110);
    chk("bounce_no_key", key_valid, 0);

    // Rows 1 and 3 on column 3: lower row wins
    pressed[7] = 1'b1;
    pressed[15] = 1'b1;
    exp_q.push_back(4'd7);
    wait_col("prio_col_reached", 4'b0111);
    wait_ticks(4);
    #1;
    chk("prio_valid", key_valid, 1);
    chk("prio_code", key_code, 7);
    pressed = '0;
    wait_ticks(6);

    // Overrun: key 5 never accepted, key 10 overwrites it
    key_ready = 1'b0;
    pressed[5] = 1'b1;
    wait_valid("k5_wait");
    chk("k5_code", key_code, 5);
    chk("k5_overrun", overrun, 0);
    pressed[5] = 1'b0;
    wait_ticks(6);
    #1;
    chk("k5_held_valid", key_valid, 1);
    pressed[10] = 1'b1;
    exp_q.push_back(4'd10);
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(posedge clk);
      #1;
      if (key_code === 4'd10) found = 1'b1;
    end
    chk("k10_wait", found, 1);
    chk("k10_valid", key_valid, 1);
    chk("k10_overrun", overrun, 1);
    pressed[10] = 1'b0;
    key_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("k10_valid_drop", key_valid, 0);
    chk("overrun_sticky", overrun, 1);
    wait_ticks(6);

    // Asynchronous reset while holding an unaccepted '*'
    key_ready = 1'b0;
    pressed[KEY_STAR] = 1'b1;
    wait_valid("star_wait");
    chk("star_code", key_code, KEY_STAR);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_col", col_o, 4'b1110);
    chk("arst_valid", key_valid, 0);
    chk("arst_code", key_code, 0);
    chk("arst_overrun", overrun, 0);
    pressed = '0;
    @(negedge clk);
    rst = 1'b0;
    wait_ticks(2);
    #1;
    chk("post_rst_col", col_o, 4'b1011);
    chk("post_rst_valid", key_valid, 0);

    chk("queue_drained", exp_q.size(), 0);
    chk("accept_count", n_accept, 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
